// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: control FSM for one SHA-256 compression block per run.
// It drives the IV load, the working-variable load, the round index and the final
// chaining-value add. It also tracks the block count and whether H0-H7 hold a
// finished digest.
module sha256_block_sequencer #(
    parameter int ROUNDS = 64,
    parameter int RIDX_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              first_block,
    input  logic              last_block,
    input  logic              abort,
    output logic              busy,
    output logic              h_init,
    output logic              load_work,
    output logic              round_en,
    output logic [RIDX_W-1:0] round_idx,
    output logic              w_from_msg,
    output logic              h_update,
    output logic              done,
    output logic              digest_valid,
    output logic [CNT_W-1:0]  block_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HINIT  = 3'd1,
        LOAD   = 3'd2,
        ROUND  = 3'd3,
        UPDATE = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_nx;
    logic   last_q;
    logic   accept;

    // A start only counts in IDLE, and a simultaneous abort suppresses it.
    assign accept = (state == IDLE) && start && !abort;

    // Next-state logic and per-state pulse outputs.
    always_comb begin
        state_nx   = state;
        busy       = (state != IDLE);
        h_init     = 1'b0;
        load_work  = 1'b0;
        round_en   = 1'b0;
        w_from_msg = 1'b0;
        h_update   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:   if (accept) state_nx = first_block ? HINIT : LOAD;
            HINIT:  begin h_init = 1'b1; state_nx = LOAD; end
            LOAD:   begin load_work = 1'b1; state_nx = ROUND; end
            ROUND: begin
                round_en   = 1'b1;
                // Rounds 0..15 take W directly from the message block.
                w_from_msg = (32'(round_idx) < 32'd16);
                if (round_idx == RIDX_W'(ROUNDS - 1)) state_nx = UPDATE;
            end
            UPDATE: begin h_update = 1'b1; state_nx = DONE; end
            DONE:   begin done = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
        // Cancel any run in flight. Pulses for the current state still go out this cycle.
        if (abort && state != IDLE) state_nx = IDLE;
    end

    // State register, round counter, latched flags and block accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            round_idx    <= '0;
            last_q       <= 1'b0;
            digest_valid <= 1'b0;
            block_cnt    <= '0;
        end else begin
            state <= state_nx;
            // Keep round_idx at 0 everywhere except inside an ongoing ROUND phase,
            // so an abort or the final round leaves it ready for the next run.
            if (state == ROUND && state_nx == ROUND)
                round_idx <= round_idx + RIDX_W'(1);
            else
                round_idx <= '0;
            if (accept) begin
                last_q       <= last_block;
                digest_valid <= 1'b0;
                if (first_block) block_cnt <= '0;
            end
            // The done pulse marks a completed block, so account for it even if
            // an abort arrives in the same cycle.
            if (state == DONE) begin
                block_cnt <= block_cnt + CNT_W'(1);
                if (last_q) digest_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: cycle-exact checks of every output
// across normal, multi-block, busy-start, abort, reset and counter-wrap runs.
module tb_sha256_block_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, first_block, last_block, abort;
    logic       busy, h_init, load_work, round_en, w_from_msg, h_update, done, digest_valid;
    logic [5:0] round_idx;
    logic [7:0] block_cnt;
    // Narrow-counter instance sharing the same stimulus.
    logic       busy2, h_init2, load_work2, round_en2, w_from_msg2, h_update2, done2, digest_valid2;
    logic [5:0] round_idx2;
    logic [1:0] block_cnt2;

    int total = 0;
    int bad   = 0;

    sha256_block_sequencer #(.ROUNDS(64), .RIDX_W(6), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .first_block(first_block),
        .last_block(last_block), .abort(abort), .busy(busy), .h_init(h_init),
        .load_work(load_work), .round_en(round_en), .round_idx(round_idx),
        .w_from_msg(w_from_msg), .h_update(h_update), .done(done),
        .digest_valid(digest_valid), .block_cnt(block_cnt)
    );

    sha256_block_sequencer #(.ROUNDS(64), .RIDX_W(6), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .first_block(first_block),
        .last_block(last_block), .abort(abort), .busy(busy2), .h_init(h_init2),
        .load_work(load_work2), .round_en(round_en2), .round_idx(round_idx2),
        .w_from_msg(w_from_msg2), .h_update(h_update2), .done(done2),
        .digest_valid(digest_valid2), .block_cnt(block_cnt2)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one start and check every cycle of the run against the cycle-table
    // model. start_c/abort_c/reset_c (>0) inject events at that cycle number.
    task automatic run_block(input bit first, input bit last, input int start_c,
                             input int abort_c, input int reset_c,
                             input logic [7:0] cnt0, input string tag);
        int         off, ld, r0, up, dn, idx;
        bit         aborted, e_rnd;
        logic [7:0] cnt_run, e_cnt;
        logic [7:0] e_flags, o_flags;
        logic [5:0] e_idx, o_idx;
        off     = first ? 0 : 1;
        ld      = 2 - off;
        r0      = 3 - off;
        up      = 67 - off;
        dn      = 68 - off;
        aborted = 1'b0;
        cnt_run = first ? 8'd0 : cnt0;
        start = 1'b1; first_block = first; last_block = last;
        tick;
        start = 1'b0; first_block = 1'b0; last_block = 1'b0;
        for (int c = 1; c <= dn + 1; c++) begin
            idx   = c - r0;
            e_rnd = !aborted && c >= r0 && c <= r0 + 63;
            e_idx = e_rnd ? 6'(idx) : 6'd0;
            e_cnt = (!aborted && c == dn + 1) ? cnt_run + 8'd1 : cnt_run;
            if (aborted)
                e_flags = 8'b0;
            else
                e_flags = {c <= dn, first && c == 1, c == ld, e_rnd,
                           e_rnd && idx < 16, c == up, c == dn,
                           (c == dn + 1) ? last : 1'b0};
            o_flags = {busy, h_init, load_work, round_en, w_from_msg, h_update, done, digest_valid};
            o_idx   = e_rnd ? round_idx : 6'd0;
            total++;
            if ({o_flags, o_idx, block_cnt} !== {e_flags, e_idx, e_cnt}) begin
                bad++;
                $display("FAIL %s cycle %0d: got flags=%b idx=%0d cnt=%0d, want flags=%b idx=%0d cnt=%0d",
                         tag, c, o_flags, o_idx, block_cnt, e_flags, e_idx, e_cnt);
            end
            if (aborted || c == dn + 1) return;
            if (c == reset_c) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                total++;
                if ({busy, h_init, load_work, round_en, w_from_msg, h_update, done,
                     digest_valid, round_idx, block_cnt} !== 22'd0) begin
                    bad++;
                    $display("FAIL %s after reset: got busy=%b idx=%0d cnt=%0d dv=%b, want all 0",
                             tag, busy, round_idx, block_cnt, digest_valid);
                end
                return;
            end
            if (c == abort_c) begin
                abort = 1'b1;
                tick;
                abort   = 1'b0;
                aborted = 1'b1;
            end else if (c == start_c) begin
                start = 1'b1; first_block = 1'b1; last_block = 1'b0;
                tick;
                start = 1'b0; first_block = 1'b0;
            end else begin
                tick;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; first_block = 1'b0; last_block = 1'b0; abort = 1'b0;
        tick; tick;
        reset = 1'b0;
        total++;
        if ({busy, h_init, load_work, round_en, w_from_msg, h_update, done,
             digest_valid, round_idx, block_cnt} !== 22'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b idx=%0d cnt=%0d dv=%b, want all 0",
                     busy, round_idx, block_cnt, digest_valid);
        end
    endtask

    task automatic test_single;
        run_block(1'b1, 1'b1, 0, 0, 0, 8'd0, "single");
        total++;
        if (block_cnt !== 8'd1 || digest_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_end: got cnt=%0d dv=%b, want cnt=1 dv=1", block_cnt, digest_valid);
        end
    endtask

    task automatic test_two_block;
        run_block(1'b1, 1'b0, 0, 0, 0, 8'd0, "two_blk1");
        total++;
        if (digest_valid !== 1'b0) begin
            bad++;
            $display("FAIL two_blk1_dv: got %b want 0", digest_valid);
        end
        run_block(1'b0, 1'b1, 0, 0, 0, 8'd1, "two_blk2");
        total++;
        if (block_cnt !== 8'd2 || digest_valid !== 1'b1) begin
            bad++;
            $display("FAIL two_blk_end: got cnt=%0d dv=%b, want cnt=2 dv=1", block_cnt, digest_valid);
        end
    endtask

    // start at round_idx 30 (first_block=0 -> round 0 at cycle 2, so cycle 32).
    task automatic test_start_busy;
        run_block(1'b0, 1'b1, 32, 0, 0, 8'd2, "start_busy");
        tick;
        total++;
        if (busy !== 1'b0 || block_cnt !== 8'd3) begin
            bad++;
            $display("FAIL start_busy_idle: got busy=%b cnt=%0d, want busy=0 cnt=3", busy, block_cnt);
        end
    endtask

    // abort at round_idx 10 (cycle 12 with first_block=0), then abort+start in IDLE.
    task automatic test_abort;
        run_block(1'b0, 1'b1, 0, 12, 0, 8'd3, "abort");
        total++;
        if (block_cnt !== 8'd3 || digest_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_end: got cnt=%0d dv=%b, want cnt=3 dv=0", block_cnt, digest_valid);
        end
        start = 1'b1; abort = 1'b1; first_block = 1'b1; last_block = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0; first_block = 1'b0; last_block = 1'b0;
        total++;
        if (busy !== 1'b0 || h_init !== 1'b0 || block_cnt !== 8'd3) begin
            bad++;
            $display("FAIL abort_start_idle: got busy=%b h_init=%b cnt=%0d, want 0 0 3",
                     busy, h_init, block_cnt);
        end
    endtask

    // reset at round_idx 20 (cycle 23 with first_block=1), then a clean run.
    task automatic test_reset_mid;
        run_block(1'b1, 1'b0, 0, 0, 23, 8'd0, "reset_mid");
        run_block(1'b0, 1'b1, 0, 0, 0, 8'd0, "after_reset");
        total++;
        if (block_cnt !== 8'd1 || digest_valid !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_end: got cnt=%0d dv=%b, want cnt=1 dv=1", block_cnt, digest_valid);
        end
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] seq [6];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        for (int b = 0; b < 6; b++) begin
            run_block(b == 0, 1'b0, 0, 0, 0, 8'(b), "cnt_wrap");
            total++;
            if (block_cnt2 !== seq[b]) begin
                bad++;
                $display("FAIL cnt_wrap block %0d: got %0d want %0d", b, block_cnt2, seq[b]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_two_block;
        test_start_busy;
        test_abort;
        test_reset_mid;
        test_cnt_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Controls the SHA-256 compression datapath for one 512-bit message block per run.
- Initialises the H0–H7 chaining-value registers to the IV and loads the working variables a–h from them.
- Steps the round index through all rounds, then pulses the final chaining-value add.
- Sits between the mining front end (message/nonce feeder) and the round core plus H0–H7 accumulator registers. Supports multi-block messages via first/last block flags.

Parameters:
- ROUNDS, 64, number of compression rounds per block.
- RIDX_W, 6, width of round_idx; must satisfy 2^RIDX_W >= ROUNDS.
- CNT_W, 8, width of block_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to compress one block; sampled only in IDLE.
- first_block  input  1  sampled with accepted start; 1 = reinitialise H0–H7 to the IV first.
- last_block  input  1  sampled with accepted start; 1 = this block completes the message.
- abort  input  1  synchronous cancel of the current run.
- busy  output  1  high in every state except IDLE.
- h_init  output  1  one-cycle pulse; H0–H7 registers load the IV.
- load_work  output  1  one-cycle pulse; a–h load from H0–H7.
- round_en  output  1  high for exactly ROUNDS consecutive cycles per run.
- round_idx  output  RIDX_W  current round t, valid while round_en = 1.
- w_from_msg  output  1  high while round_en = 1 and round_idx < 16; selects message word over expanded schedule.
- h_update  output  1  one-cycle pulse; Hn <= Hn + working variable (mod 2^32).
- done  output  1  one-cycle pulse at end of every non-aborted run.
- digest_valid  output  1  level; H0–H7 hold a final message digest.
- block_cnt  output  CNT_W  blocks completed since the last first_block run.

Behaviour:
- Reset values: all outputs 0, round_idx 0, block_cnt 0, state IDLE. Reset dominates every other input, including mid-run.
- States: IDLE, HINIT, LOAD, ROUND, UPDATE, DONE.
- IDLE: when start = 1, latch first_block and last_block and clear digest_valid.
  - Next state is HINIT if first_block = 1, otherwise LOAD.
  - If first_block = 1, also clear block_cnt.
- HINIT: h_init = 1 for one cycle, then go to LOAD.
- LOAD: load_work = 1 for one cycle, then go to ROUND with round_idx = 0.
- ROUND: round_en = 1 every cycle; round_idx increments by 1 each cycle.
  - At round_idx = ROUNDS-1, go to UPDATE next cycle and return round_idx to 0 (no wrap past ROUNDS-1).
- UPDATE: h_update = 1 for one cycle, then go to DONE.
- DONE: done = 1 for one cycle.
  - block_cnt increments, wrapping modulo 2^CNT_W.
  - digest_valid is set if the latched last_block = 1.
  - Then go to IDLE.
- Latency: start accepted at cycle 0.
  - With first_block = 1: HINIT at cycle 1, LOAD at 2, ROUND at 3–66, UPDATE at 67, DONE at 68.
  - With first_block = 0: every event is one cycle earlier, DONE at 67.
- The earliest next start is accepted the cycle after DONE, i.e. in IDLE.
- start while busy: ignored and not queued. first_block and last_block are ignored outside accepted starts.
- abort in any non-IDLE state: next state is IDLE.
  - No h_update or done is issued for that run; pulses due in the abort cycle are still issued as per current state.
  - block_cnt is unchanged.
  - digest_valid stays 0, because it was cleared at the accepted start.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins, start is not accepted.
- Every pulse output is exactly one cycle wide and mutually exclusive with the other pulses.

Test Plan:
- Reset mid-ROUND (round_idx = 20) -> next cycle all outputs 0, IDLE; a start afterwards runs normally from round 0.
- Single block (start, first_block = 1, last_block = 1 at cycle 0):
  - h_init at cycle 1, load_work at 2.
  - round_en cycles 3–66 with round_idx 0..63; w_from_msg high cycles 3–18.
  - h_update at 67, done at 68; digest_valid = 1 from cycle 69.
  - block_cnt = 1.
- Two-block message (block 1: first = 1, last = 0; block 2 started the cycle after DONE with first = 0, last = 1):
  - No h_init in block 2; block 2 DONE 67 cycles after its start.
  - digest_valid stays 0 after block 1 and becomes 1 after block 2; block_cnt = 2.
- start pulsed at round_idx = 30 -> ignored; exactly one done, timing unchanged.
- abort at round_idx = 10 -> IDLE next cycle, no h_update, no done, block_cnt and digest_valid unchanged from the accepted start.
- CNT_W = 2 with 5 consecutive non-first blocks after a first block -> block_cnt sequence 1, 2, 3, 0, 1, 2.
